// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, key index-to-code mapping and scan FSM states
// for the keypad scanner slice.
package keypad_pkg;

  localparam logic [3:0] KEY_IDLE  = 4'hE;
  localparam logic [3:0] KEY_RESET = 4'hF;

  typedef enum logic {
    S_DRIVE,
    S_EVAL
  } scan_state_t;

  // Key index is row*4 + col on the physical matrix:
  //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'hC;
      4'd12:   code = KEY_IDLE;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_RESET;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: the keyPress interface between the scanner (master)
// and the game controller (slave).
interface keypad_scanner_if;
  logic [3:0] keyPress;
  logic       key_valid;
  logic       key_strobe;

  modport master (output keyPress, output key_valid, output key_strobe);
  modport slave  (input  keyPress, input  key_valid, input  key_strobe);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: commits a scan candidate once it has been seen on
// DEBOUNCE_SCANS consecutive scans. Optional auto-repeat strobes are built
// when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_SCANS = 200
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       eval,
  input  logic       cand_valid,
  input  logic [3:0] cand_idx,
  output logic [3:0] code,
  output logic       valid,
  output logic       strobe
);

  localparam int unsigned SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [SW-1:0] stable, stable_n;
  logic          prev_v;
  logic [3:0]    prev_i;
  logic          com_v;
  logic [3:0]    com_i;
  logic          same, differs, commit, rep_fire;

  // Next stable count and the commit decision for the scan being evaluated.
  always_comb begin
    same    = (cand_valid == prev_v) && (!cand_valid || (cand_idx == prev_i));
    differs = (cand_valid != com_v) || (cand_valid && (cand_idx != com_i));
    if (!same)
      stable_n = SW'(1);
    else if (stable == SW'(DEBOUNCE_SCANS))
      stable_n = stable;
    else
      stable_n = stable + SW'(1);
    commit = eval && (stable_n == SW'(DEBOUNCE_SCANS)) && differs;
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  logic [RW-1:0] rep;

  assign rep_fire = eval && !commit && com_v && (rep == RW'(REPEAT_SCANS - 1));

  // Count evaluated scans while a real key stays committed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rep <= '0;
    else if (eval) begin
      if (commit || rep_fire || !com_v)
        rep <= '0;
      else
        rep <= rep + RW'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Candidate history, committed key and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      prev_v <= 1'b0;
      prev_i <= '0;
      com_v  <= 1'b0;
      com_i  <= '0;
      code   <= KEY_IDLE;
      valid  <= 1'b0;
      strobe <= 1'b0;
    end else begin
      strobe <= rep_fire;
      if (eval) begin
        prev_v <= cand_valid;
        prev_i <= cand_idx;
        stable <= stable_n;
        if (commit) begin
          com_v  <= cand_valid;
          com_i  <= cand_idx;
          code   <= cand_valid ? key_code(cand_idx) : KEY_IDLE;
          valid  <= cand_valid;
          strobe <= cand_valid;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low key matrix one column at a time,
// snapshots the pressed keys and hands a single-key candidate to the
// debouncer once per scan. Auto-repeat is built with KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_SCANS = 200
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                row,
  output logic [3:0]                col,
  keypad_scanner_if.master          kp
);

  localparam int unsigned DW = $clog2(SCAN_DIV);

  logic [3:0]    row_meta, row_sync;
  scan_state_t   state;
  logic [1:0]    c;
  logic [DW-1:0] div;
  logic [15:0]   snap;
  logic [4:0]    ones;
  logic [3:0]    idx;
  logic          cand_valid;

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Column drive FSM: sample rows on the last cycle of each column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_DRIVE;
      c     <= '0;
      div   <= '0;
      snap  <= '0;
      col   <= 4'b1110;
    end else begin
      case (state)
        S_DRIVE: begin
          if (div == DW'(SCAN_DIV - 1)) begin
            for (int unsigned r = 0; r < 4; r++)
              snap[{r[1:0], c}] <= ~row_sync[r];
            div <= '0;
            if (c == 2'd3) begin
              state <= S_EVAL;
              c     <= '0;
              col   <= 4'b1111;
            end else begin
              c   <= c + 2'd1;
              col <= ~(4'b0001 << (c + 2'd1));
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        S_EVAL: begin
          state <= S_DRIVE;
          col   <= 4'b1110;
        end
        default: begin
          state <= S_DRIVE;
          col   <= 4'b1110;
        end
      endcase
    end
  end

  // Exactly one pressed key forms a candidate; '*' is folded into "none"
  // here since it reports the idle code and must never raise key_valid.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (snap[i]) begin
        ones = ones + 5'd1;
        idx  = i[3:0];
      end
    end
    cand_valid = (ones == 5'd1) && !snap[12];
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
`ifdef KEYPAD_AUTOREPEAT_EN
    , .REPEAT_SCANS (REPEAT_SCANS)
`endif
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .eval       (state == S_EVAL),
    .cand_valid (cand_valid),
    .cand_idx   (idx),
    .code       (kp.keyPress),
    .valid      (kp.key_valid),
    .strobe     (kp.key_strobe)
  );

endmodule
